// File: rtl/logit5slices_pkg.sv
// logit5slices_pkg: shared constants for the 5-slice piecewise-linear logit.
//   W          data width, signed Q5.11
//   slice_t    slice index (3 bits, values 0..4)
//   YSAT       saturated magnitude, ln(63) in Q5.11
//   brk()      slice breakpoint D[k] on the folded distance d (Q0.11)
//   slope()    slice slope M[k] (Q6.8)
//   base()     slice base value F[k] (Q5.11)
package logit5slices_pkg;

   localparam int unsigned W     = 16;
   localparam int unsigned IDX_W = 3;

   typedef logic [IDX_W-1:0] slice_t;

   localparam logic [W-1:0]  YSAT    = 16'd8485;
   localparam logic [10:0]   D_LIMIT = 11'd992;

   function automatic logic [10:0] brk(input slice_t k);
      case (k)
         3'd1:    brk = 11'd512;
         3'd2:    brk = 11'd768;
         3'd3:    brk = 11'd896;
         3'd4:    brk = 11'd960;
         default: brk = 11'd0;
      endcase
   endfunction

   function automatic logic [13:0] slope(input slice_t k);
      case (k)
         3'd1:    slope = 14'd1735;
         3'd2:    slope = 14'd3121;
         3'd3:    slope = 14'd5949;
         3'd4:    slope = 14'd11617;
         default: slope = 14'd1125;
      endcase
   endfunction

   function automatic logic [W-1:0] base(input slice_t k);
      case (k)
         3'd1:    base = 16'd2250;
         3'd2:    base = 16'd3985;
         3'd3:    base = 16'd5546;
         3'd4:    base = 16'd7033;
         default: base = 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/logit5slices_if.sv
// logit5slices_if: two-lane probability-in / logit-out stream bundle.
//   p0_in, p1_in  lane probabilities, signed Q5.11   (master -> slave)
//   valid_in      input pair valid                   (master -> slave)
//   y0_out,y1_out lane logits, signed Q5.11          (slave -> master)
//   valid_out     output pair valid                  (slave -> master)
interface logit5slices_if;
   import logit5slices_pkg::*;

   logic [W-1:0] p0_in;
   logic [W-1:0] p1_in;
   logic         valid_in;
   logic [W-1:0] y0_out;
   logic [W-1:0] y1_out;
   logic         valid_out;

   modport master (output p0_in, p1_in, valid_in,
                   input  y0_out, y1_out, valid_out);

   modport slave  (input  p0_in, p1_in, valid_in,
                   output y0_out, y1_out, valid_out);
endinterface

// File: rtl/logit5slices_lane.sv
// logit_lane: one lane of the 3-stage logit datapath.
//   S1 fold/classify, S2 slope multiply, S3 base add / saturate / sign.
//   clk  clock, rising edge
//   rst  asynchronous reset, active-high
//   p_i  probability, signed Q5.11
//   y_o  logit, signed Q5.11 (3 clocks after p_i)
// Build option: LOGIT_ROUND_EN selects round-half-up in S2 instead of truncation.
module logit_lane
   import logit5slices_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] p_i,
   output logic [W-1:0] y_o
);

   // S1: fold around p = 0.5 and pick the slice
   logic [W:0]  diff, absdiff;
   logic        s1_s_d, s1_sat_d;
   logic [10:0] d_d, s1_doff_d;
   slice_t      s1_k_d;

   logic        s1_s_q, s1_sat_q;
   logic [10:0] s1_doff_q;
   slice_t      s1_k_q;

   always_comb begin
      diff    = {p_i[W-1], p_i} - 17'd1024;
      absdiff = diff[W] ? (17'd0 - diff) : diff;
      d_d     = 11'(absdiff);
      s1_s_d  = ($signed(p_i) >= 16'sd1024);
      // Range test is on the full-width distance so out-of-range p never aliases into a slice
      s1_sat_d = ($signed(p_i) <= 16'sd0) || ($signed(p_i) >= 16'sd2048) ||
                 (absdiff >= {6'd0, D_LIMIT});
      if      (d_d >= brk(3'd4)) s1_k_d = 3'd4;
      else if (d_d >= brk(3'd3)) s1_k_d = 3'd3;
      else if (d_d >= brk(3'd2)) s1_k_d = 3'd2;
      else if (d_d >= brk(3'd1)) s1_k_d = 3'd1;
      else                       s1_k_d = 3'd0;
      s1_doff_d = d_d - brk(s1_k_d);
   end

   // S2: slope multiply
   logic [24:0] prod;
   logic [16:0] s2_frac_d;
   logic        s2_s_q, s2_sat_q;
   slice_t      s2_k_q;
   logic [16:0] s2_frac_q;

   always_comb begin
`ifdef LOGIT_ROUND_EN
      prod = 25'(s1_doff_q) * 25'(slope(s1_k_q)) + 25'd128;
`else
      prod = 25'(s1_doff_q) * 25'(slope(s1_k_q));
`endif
      s2_frac_d = 17'(prod >> 8);
   end

   // S3: combine
   logic [16:0]  mag, mag_sel;
   logic [W-1:0] y_d, y_q;

   always_comb begin
      mag     = {1'b0, base(s2_k_q)} + s2_frac_q;
      mag_sel = s2_sat_q ? {1'b0, YSAT} : mag;
      y_d     = s2_s_q ? 16'(mag_sel) : 16'(17'd0 - mag_sel);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_s_q    <= 1'b0;
         s1_sat_q  <= 1'b0;
         s1_k_q    <= '0;
         s1_doff_q <= '0;
         s2_s_q    <= 1'b0;
         s2_sat_q  <= 1'b0;
         s2_k_q    <= '0;
         s2_frac_q <= '0;
         y_q       <= '0;
      end else begin
         s1_s_q    <= s1_s_d;
         s1_sat_q  <= s1_sat_d;
         s1_k_q    <= s1_k_d;
         s1_doff_q <= s1_doff_d;
         s2_s_q    <= s1_s_q;
         s2_sat_q  <= s1_sat_q;
         s2_k_q    <= s1_k_q;
         s2_frac_q <= s2_frac_d;
         y_q       <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/logit5slices.sv
// logit5slices: two-lane piecewise-linear logit y = ln(p/(1-p)), Q5.11 in/out.
//   Fully pipelined, one pair per clock, latency 3, no backpressure.
//   clk  clock, rising edge
//   rst  asynchronous reset, active-high
//   bus  logit5slices_if.slave: p0_in/p1_in/valid_in in, y0_out/y1_out/valid_out out
// Build option: LOGIT_ROUND_EN (round-half-up in the multiply stage).
module logit5slices
   import logit5slices_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   logit5slices_if.slave        bus
);

   logic [W-1:0] y0, y1;
   logic [2:0]   vld_q, vld_d;

   logit_lane u_lane0 (.clk(clk), .rst(rst), .p_i(bus.p0_in), .y_o(y0));
   logit_lane u_lane1 (.clk(clk), .rst(rst), .p_i(bus.p1_in), .y_o(y1));

   always_comb vld_d = {vld_q[1:0], bus.valid_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   assign bus.y0_out    = y0;
   assign bus.y1_out    = y1;
   assign bus.valid_out = vld_q[2];

endmodule

// File: tb/tb_logit5slices.sv
module tb_logit5slices;
   import logit5slices_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logit5slices_if bus ();

   logit5slices dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct { int due; int y0; int y1; } exp_t;
   exp_t q[$];

   // Reference: logit approximation straight from the slice tables
   function automatic int ref_logit(input int p);
      int dt[5] = '{0, 512, 768, 896, 960};
      int mt[5] = '{1125, 1735, 3121, 5949, 11617};
      int ft[5] = '{0, 2250, 3985, 5546, 7033};
      int d, k, mag;
      if (p <= 0)    return -8485;
      if (p >= 2048) return 8485;
      d = (p >= 1024) ? p - 1024 : 1024 - p;
      if (d >= 992) mag = 8485;
      else begin
         k = 0;
         for (int i = 1; i < 5; i++) if (d >= dt[i]) k = i;
`ifdef LOGIT_ROUND_EN
         mag = ft[k] + ((d - dt[k]) * mt[k] + 128) / 256;
`else
         mag = ft[k] + ((d - dt[k]) * mt[k]) / 256;
`endif
      end
      return (p >= 1024) ? mag : -mag;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One clock: check outputs due this cycle, then drive the next input pair
   task automatic step(input logic v, input int p0, input int p1, input int e0, input int e1);
      exp_t e;
      @(negedge clk);
      cyc++;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("valid_out", {15'd0, bus.valid_out}, 16'd1);
         chk("y0", bus.y0_out, 16'(e.y0));
         chk("y1", bus.y1_out, 16'(e.y1));
      end else begin
         chk("valid_out_idle", {15'd0, bus.valid_out}, 16'd0);
      end
      bus.valid_in = v;
      bus.p0_in    = 16'(p0);
      bus.p1_in    = 16'(p1);
      if (v) q.push_back('{cyc + 3, e0, e1});
   endtask

   task automatic step_m(input logic v, input int p0, input int p1);
      step(v, p0, p1, ref_logit(p0), ref_logit(p1));
   endtask

   task automatic drain();
      for (int i = 0; i < 5; i++) step_m(1'b0, 0, 0);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("rst_y0", bus.y0_out, 16'd0);
      chk("rst_y1", bus.y1_out, 16'd0);
      q.delete();
      bus.valid_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b0;
   endtask

   int ap[10] = '{1024, 1536, 512, 1792, 1280, 0, -2048, 2040, 2048, 4096};
   int ay[10] = '{0, 2250, -2250, 3985, 1125, -8485, -8485, 8485, 8485, 8485};
   int rp0, rp1;

   initial begin
      bus.valid_in = 1'b0;
      bus.p0_in    = '0;
      bus.p1_in    = '0;
      #1;
      chk("init_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("init_y0", bus.y0_out, 16'd0);
      do_reset();

      // Anchors and saturation, lane 1 offset so lanes see different values
      for (int i = 0; i < 10; i++)
         step(1'b1, ap[i], ap[(i + 5) % 10], ay[i], ay[(i + 5) % 10]);
      drain();

      // Identical inputs on both lanes
      step_m(1'b1, 1700, 1700);
      step_m(1'b1, 300, 300);
      drain();

      // 20 back-to-back random pairs across 0..2048
      for (int i = 0; i < 20; i++) begin
         rp0 = int'($urandom_range(2048));
         rp1 = int'($urandom_range(2048));
         step_m(1'b1, rp0, rp1);
      end
      drain();

      // Random full-range values with gaps in valid
      for (int i = 0; i < 30; i++) begin
         rp0 = int'($urandom_range(65535)) - 32768;
         rp1 = int'($urandom_range(2200)) - 100;
         step_m(1'($urandom_range(1)), rp0, rp1);
      end
      drain();

      // Reset mid-stream drops in-flight pairs
      for (int i = 0; i < 5; i++) step_m(1'b1, 600 + 200 * i, 1900 - 150 * i);
      do_reset();
      for (int i = 0; i < 6; i++) step_m(1'b1, 100 + 300 * i, 2000 - 300 * i);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
